// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port asynchronous SRAM controller with fixed read/write pulse widths.
// Pin values are registered from the next state, so pins always match the current state.
module sram_ctrl #(
    parameter int ADDR_BITS   = 18,
    parameter int DATA_BITS   = 16,
    parameter int RD_CYCLES   = 6,
    parameter int WR_CYCLES   = 6,
    parameter int TURN_CYCLES = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [ADDR_BITS-1:0] cmd_addr_i,
    input  logic [DATA_BITS-1:0] cmd_wdata_i,
    input  logic [1:0]           cmd_be_i,
    output logic                 rd_valid_o,
    output logic [DATA_BITS-1:0] rd_data_o,
    output logic                 sram_ce1_n_o,
    output logic                 sram_ce2_o,
    output logic                 sram_we_n_o,
    output logic                 sram_oe_n_o,
    output logic                 sram_bhe_n_o,
    output logic                 sram_ble_n_o,
    output logic [ADDR_BITS-1:0] sram_addr_o,
    inout  wire  [DATA_BITS-1:0] sram_dq_io
);
    typedef enum logic [2:0] {IDLE, RD, TURN, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
    localparam int LB = DATA_BITS / 2;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d, lane_mask;
    logic [1:0]           be_q, be_d;
    logic                 accept, rd_sample, rd_pend_q, rd_valid_q, ready_q;
    logic                 ce1_n_q, ce2_q, we_n_q, oe_n_q, bhe_n_q, ble_n_q, dq_oe_q;

    assign accept    = cmd_valid_i & ready_q;
    assign lane_mask = {{LB{be_q[1]}}, {LB{be_q[0]}}};
    assign rd_sample = (state_q == RD) && (state_d == TURN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        addr_d    = accept ? cmd_addr_i : addr_q;
        wdata_d   = accept ? cmd_wdata_i : wdata_q;
        be_d      = accept ? cmd_be_i : be_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) state_d = cmd_write_i ? WR_SETUP : RD;
            end
            RD: if (cnt_q == 16'(RD_CYCLES - 1)) begin
                state_d = TURN;
                cnt_d   = '0;
            end
            TURN: if (cnt_q == 16'(TURN_CYCLES - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = '0;
            end
            WR_PULSE: if (cnt_q == 16'(WR_CYCLES - 1)) begin
                state_d = WR_HOLD;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        rd_data_d = rd_sample ? (sram_dq_io & lane_mask) : rd_data_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rd_data_q  <= '0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            ce1_n_q    <= 1'b1;
            ce2_q      <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            bhe_n_q    <= 1'b1;
            ble_n_q    <= 1'b1;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rd_data_q  <= rd_data_d;
            // valid trails the sample by one clock so it lands RD_CYCLES+1 after accept
            rd_pend_q  <= rd_sample;
            rd_valid_q <= rd_pend_q;
            ready_q    <= state_d == IDLE;
            ce1_n_q    <= state_d == IDLE;
            ce2_q      <= state_d != IDLE;
            we_n_q     <= state_d != WR_PULSE;
            oe_n_q     <= state_d != RD;
            bhe_n_q    <= (state_d == IDLE) | ~be_d[1];
            ble_n_q    <= (state_d == IDLE) | ~be_d[0];
            dq_oe_q    <= state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
        end
    end

    assign cmd_ready_o  = ready_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign sram_ce1_n_o = ce1_n_q;
    assign sram_ce2_o   = ce2_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_bhe_n_o = bhe_n_q;
    assign sram_ble_n_o = ble_n_q;
    assign sram_addr_o  = addr_q;
    assign sram_dq_io   = dq_oe_q ? wdata_q : {DATA_BITS{1'bz}};
endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ADDR_BITS, 18, SRAM address width.
- DATA_BITS, 16, SRAM data width; two byte lanes.
- RD_CYCLES, 6, clocks of OE_n low per read; legal range >= 2.
- WR_CYCLES, 6, clocks of WE_n low per write; legal range >= 2.
- TURN_CYCLES, 1, bus turnaround clocks after a read; legal range >= 1.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk_i, in, 1, sole clock.
- rst_i, in, 1, asynchronous active-high reset.
- cmd_valid_i, in, 1, command present.
- cmd_ready_o, out, 1, controller can accept a command.
- cmd_write_i, in, 1, 1 = write, 0 = read.
- cmd_addr_i, in, ADDR_BITS, word address.
- cmd_wdata_i, in, DATA_BITS, write data.
- cmd_be_i, in, 2, byte enables; bit1 = upper byte, bit0 = lower byte.
- rd_valid_o, out, 1, one-cycle read-data strobe.
- rd_data_o, out, DATA_BITS, read data.
- sram_ce1_n_o, sram_ce2_o, sram_we_n_o, sram_oe_n_o, sram_bhe_n_o, sram_ble_n_o, out, 1 each, SRAM control pins.
- sram_addr_o, out, ADDR_BITS, SRAM address.
- sram_dq_io, inout, DATA_BITS, SRAM data bus.
REQ-003 The block SHALL use one clock, clk_i; rst_i SHALL be asynchronous and active-high.

Function
REQ-004 All outputs and the DQ output enable SHALL be registered.
REQ-005 The FSM SHALL have the states IDLE, RD, TURN, WR_SETUP, WR_PULSE and WR_HOLD.
REQ-006 cmd_ready_o SHALL be 1 only in IDLE; command inputs SHALL be ignored when cmd_ready_o = 0.
REQ-007 On a clock edge with cmd_valid_i & cmd_ready_o, the block SHALL latch addr, wdata and be, then enter RD (read) or WR_SETUP (write).
REQ-008 In IDLE, pins SHALL be: ce1_n=1, ce2=0, oe_n=1, we_n=1, bhe_n=1, ble_n=1, DQ high-Z; sram_addr_o SHALL hold its last value.
REQ-009 In all non-IDLE states: ce1_n=0, ce2=1, sram_addr_o = latched address, bhe_n = ~be[1], ble_n = ~be[0].
REQ-010 RD SHALL last exactly RD_CYCLES clocks with oe_n=0, we_n=1 and DQ high-Z.
REQ-011 On the RD->TURN edge, DQ SHALL be sampled into rd_data_o, with disabled byte lanes forced to 0x00.
REQ-012 rd_valid_o SHALL be high for exactly one clock, RD_CYCLES+1 clocks after the accept edge; rd_data_o SHALL hold its value until the next read.
REQ-013 TURN SHALL last TURN_CYCLES clocks with oe_n=1 and DQ high-Z, then return to IDLE.
REQ-014 WR_SETUP SHALL last 1 clock: we_n=1, oe_n=1, DQ driven with latched wdata.
REQ-015 WR_PULSE SHALL last exactly WR_CYCLES clocks: we_n=0, oe_n=1, DQ driven.
REQ-016 WR_HOLD SHALL last 1 clock: we_n=1, DQ still driven; the FSM then returns to IDLE and releases DQ.
REQ-017 oe_n=0 and DQ driven SHALL never occur in the same cycle; at least one high-Z cycle SHALL separate any read and any write on DQ.
REQ-018 be = 2'b00 SHALL execute the full cycle with both lane strobes high; a read of this kind SHALL return rd_data_o = 0 with rd_valid_o pulsed.
REQ-019 Sustained throughput SHALL be one read per RD_CYCLES+TURN_CYCLES+1 clocks and one write per WR_CYCLES+3 clocks.
REQ-020 Address 2^ADDR_BITS-1 SHALL be accessed normally with no wrap or increment logic.

Reset
REQ-021 While rst_i = 1, immediately and independent of clk_i: state=IDLE, cmd_ready_o=1, rd_valid_o=0, rd_data_o=0, ce1_n=1, ce2=0, we_n=1, oe_n=1, bhe_n=1, ble_n=1, sram_addr_o=0, DQ high-Z.
REQ-022 Reset mid-operation SHALL abort the access; an aborted read SHALL produce no rd_valid_o pulse.
REQ-023 The first command SHALL be accepted on the first clock edge after rst_i falls.

Verification
REQ-024 Write 0xA5A5 to 0x3FFFF with be=11, then read 0x3FFFF -> we_n low exactly 6 clocks; rd_valid_o 7 clocks after the read accept; rd_data_o = 0xA5A5.
REQ-025 Write 0xFFFF to 0x00010, then 0x1234 with be=01, then read with be=11 -> bhe_n=1 during the second write; read returns 0xFF34.
REQ-026 Read 0x00001 then immediately write 0x00002 -> DQ high-Z for >= 2 clocks between oe_n rising and DQ driven; oe_n=0 never coincides with DQ driven.
REQ-027 cmd_valid_i held at 1 for reads of addresses 0..3 -> accepts exactly 8 clocks apart; 4 rd_valid_o pulses.
REQ-028 rst_i asserted in the 3rd WR_PULSE clock -> we_n=1, ce1_n=1 and DQ high-Z before the next edge; cmd_ready_o=1; no rd_valid_o pulse.
REQ-029 Read with be=00 -> bhe_n = ble_n = 1 for the whole access; rd_valid_o pulses with rd_data_o = 0x0000.
